// File: rtl/hier_include_b_mux_fifo.sv
// -----------------------------------------------------------------------------
// hier_include_b_mux_fifo
//
// Multi-channel payload carrier for the hierInclude B block. Each of NUM_CH
// valid/ready input streams is buffered in its own DEPTH-entry FIFO. The FIFOs
// are merged onto one registered valid/ready output, and every output beat is
// tagged with its source channel.
//
// Arbitration:
//   default                          round-robin; the search starts one past the
//                                    last granted channel
//   HIER_INCLUDE_B_STRICT_PRIO_EN    strict priority; the lowest-index non-empty
//                                    channel always wins
//
// Ports:
//   clk        single rising-edge clock
//   rst        asynchronous, active-high reset; discards all buffered data
//   in_valid   per-channel source valid
//   in_ready   per-channel sink ready; high while that FIFO is not full
//   in_data    channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  output beat valid
//   out_ready  downstream ready
//   out_data   output payload
//   out_ch     source channel of the current output beat
//   ch_count   per-channel FIFO occupancy, $clog2(DEPTH)+1 bits per channel
//
// Parameters:
//   DATA_WIDTH  payload width; defaults to the bSt.bAnother field width
//   NUM_CH      number of input channels, 2..8
//   DEPTH       entries per channel FIFO; a power of 2, at least 2
// -----------------------------------------------------------------------------

`ifndef B_ANOTHER_SIZE
`define B_ANOTHER_SIZE 8
`endif

module hier_include_b_mux_fifo #(
    parameter int DATA_WIDTH = `B_ANOTHER_SIZE,
    parameter int NUM_CH     = 2,
    parameter int DEPTH      = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_CH-1:0]                     in_valid,
    output logic [NUM_CH-1:0]                     in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]          in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DATA_WIDTH-1:0]                 out_data,
    output logic [$clog2(NUM_CH)-1:0]             out_ch,
    output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]   ch_count
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] fifoMem [NUM_CH][DEPTH];
    logic [PTR_W-1:0]      wrPtr   [NUM_CH];
    logic [PTR_W-1:0]      rdPtr   [NUM_CH];
    logic [CNT_W-1:0]      count   [NUM_CH];

    logic [NUM_CH-1:0]     push;
    logic [NUM_CH-1:0]     pop;
    logic [NUM_CH-1:0]     nonEmpty;
    logic                  loadEn;
    logic                  anyReq;
    logic [CH_W-1:0]       grant;
    logic [DATA_WIDTH-1:0] headData;

    // Ready depends only on registered occupancy. A full FIFO refuses a push
    // even when it is popped in the same cycle, which keeps out_ready off the
    // in_ready path.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            in_ready[c]                 = (count[c] != FULL_CNT);
            nonEmpty[c]                 = (count[c] != '0);
            push[c]                     = in_valid[c] && (count[c] != FULL_CNT);
            ch_count[c*CNT_W +: CNT_W]  = count[c];
        end
    end

    assign loadEn = !out_valid || out_ready;

`ifdef HIER_INCLUDE_B_STRICT_PRIO_EN
    // Descending scan so the lowest non-empty index is the last one written.
    always_comb begin
        grant  = '0;
        anyReq = 1'b0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (nonEmpty[c]) begin
                grant  = CH_W'(c);
                anyReq = 1'b1;
            end
        end
    end
`else
    logic [CH_W-1:0] lastGrant;
    logic            hiFound;
    logic            loFound;
    logic [CH_W-1:0] hiGrant;
    logic [CH_W-1:0] loGrant;

    // Round-robin without a modulo: prefer the lowest requester above
    // lastGrant, otherwise wrap to the lowest requester at or below it.
    always_comb begin
        hiFound = 1'b0;
        loFound = 1'b0;
        hiGrant = '0;
        loGrant = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (nonEmpty[c]) begin
                if (CH_W'(c) > lastGrant) begin
                    hiFound = 1'b1;
                    hiGrant = CH_W'(c);
                end else begin
                    loFound = 1'b1;
                    loGrant = CH_W'(c);
                end
            end
        end
        anyReq = hiFound || loFound;
        grant  = hiFound ? hiGrant : loGrant;
    end

    // Reset to the top channel so that channel 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastGrant <= CH_W'(NUM_CH - 1);
        end else if (loadEn && anyReq) begin
            lastGrant <= grant;
        end
    end
`endif

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            pop[c] = loadEn && anyReq && (grant == CH_W'(c));
        end
    end

    assign headData = fifoMem[grant][rdPtr[grant]];

    // The storage array has no reset. Clearing the pointers and counts is
    // enough to discard its contents.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) begin
                fifoMem[c][wrPtr[c]] <= in_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wrPtr[c] <= '0;
                rdPtr[c] <= '0;
                count[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push[c]) begin
                    wrPtr[c] <= wrPtr[c] + PTR_W'(1);
                end
                if (pop[c]) begin
                    rdPtr[c] <= rdPtr[c] + PTR_W'(1);
                end
                count[c] <= count[c] + CNT_W'(push[c]) - CNT_W'(pop[c]);
            end
        end
    end

    // Output register. The payload is only reloaded together with a new valid
    // beat, so out_data and out_ch stay put while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (loadEn) begin
            out_valid <= anyReq;
            if (anyReq) begin
                out_data <= headData;
                out_ch   <= grant;
            end
        end
    end

endmodule

// File: tb/tb_hier_include_b_mux_fifo.sv
module tb_hier_include_b_mux_fifo;

    localparam int DW  = 8;
    localparam int NCH = 2;
    localparam int DEP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  inValid;
    wire  [1:0]  inReady;
    logic [15:0] inData;
    wire         outValid;
    logic        outReady;
    wire  [7:0]  outData;
    wire  [0:0]  outCh;
    wire  [5:0]  chCount;

    int passCnt  = 0;
    int totalCnt = 0;

    // Reference model: one queue per channel plus the output register contents.
    logic [7:0] mq [NCH][$];
    logic       mValid;
    logic [7:0] mData;
    int         mCh;
    int         mLast;

    hier_include_b_mux_fifo #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH),
        .DEPTH      (DEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_data   (inData),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_data  (outData),
        .out_ch    (outCh),
        .ch_count  (chCount)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        for (int c = 0; c < NCH; c++) mq[c].delete();
        mValid = 1'b0;
        mData  = 8'h00;
        mCh    = 0;
        mLast  = NCH - 1;
    endtask

    function automatic int pickChannel();
`ifdef HIER_INCLUDE_B_STRICT_PRIO_EN
        for (int c = 0; c < NCH; c++) if (mq[c].size() > 0) return c;
`else
        for (int i = 1; i <= NCH; i++) begin
            int idx;
            idx = (mLast + i) % NCH;
            if (mq[idx].size() > 0) return idx;
        end
`endif
        return -1;
    endfunction

    function automatic logic [5:0] expCount();
        logic [5:0] r;
        for (int c = 0; c < NCH; c++) r[c*3 +: 3] = 3'(mq[c].size());
        return r;
    endfunction

    function automatic logic [1:0] expReady();
        logic [1:0] r;
        for (int c = 0; c < NCH; c++) r[c] = (mq[c].size() != DEP);
        return r;
    endfunction

    // Advance the model by one edge using the inputs currently driven, then
    // clock the DUT and step 1 time unit past the edge.
    task automatic tick();
        logic [1:0] pushV;
        int g;
        for (int c = 0; c < NCH; c++) pushV[c] = inValid[c] && (mq[c].size() != DEP);
        if (!mValid || outReady) begin
            g = pickChannel();
            if (g >= 0) begin
                mData  = mq[g].pop_front();
                mCh    = g;
                mValid = 1'b1;
`ifndef HIER_INCLUDE_B_STRICT_PRIO_EN
                mLast  = g;
`endif
            end else begin
                mValid = 1'b0;
            end
        end
        for (int c = 0; c < NCH; c++) if (pushV[c]) mq[c].push_back(inData[c*8 +: 8]);
        @(posedge clk);
        #1;
    endtask

    task automatic resetPulse();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        modelReset();
    endtask

    task automatic test_reset();
        rst = 1'b1; inValid = 2'b00; inData = 16'h0; outReady = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        totalCnt++; if (inReady !== 2'b11) $display("FAIL reset_in_ready got=%b exp=11", inReady); else passCnt++;
        totalCnt++; if (outValid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", outValid); else passCnt++;
        totalCnt++; if (chCount !== 6'd0) $display("FAIL reset_ch_count got=%h exp=0", chCount); else passCnt++;
        totalCnt++; if (outData !== 8'h00 || outCh !== 1'b0)
            $display("FAIL reset_out_data_ch got=%h/%0d exp=00/0", outData, outCh); else passCnt++;

        // Buffer some beats, then hit reset between clock edges.
        inValid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            inData[7:0] = 8'hA0 + 8'(i);
            tick();
        end
        inValid = 2'b00;
        totalCnt++; if (chCount !== expCount() || outValid !== 1'b1)
            $display("FAIL prereset_fill got=%h/%b exp=%h/1", chCount, outValid, expCount()); else passCnt++;
        #2;
        rst = 1'b1;
        #1;
        totalCnt++; if (outValid !== 1'b0) $display("FAIL async_reset_out_valid got=%b exp=0", outValid); else passCnt++;
        totalCnt++; if (chCount !== 6'd0) $display("FAIL async_reset_ch_count got=%h exp=0", chCount); else passCnt++;
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            totalCnt++; if (outValid !== 1'b0) $display("FAIL post_reset_no_beat cyc=%0d got=%b exp=0", i, outValid); else passCnt++;
        end
    endtask

    task automatic test_single_beat();
        outReady = 1'b1;
        inValid  = 2'b10;
        inData   = {8'h5A, 8'h00};
        tick();
        inValid = 2'b00;
        totalCnt++; if (outValid !== 1'b0) $display("FAIL single_edge_k got=%b exp=0", outValid); else passCnt++;
        tick();
        totalCnt++; if (outValid !== 1'b1 || outData !== 8'h5A || outCh !== 1'b1)
            $display("FAIL single_edge_k1 got=%b/%h/%0d exp=1/5a/1", outValid, outData, outCh); else passCnt++;
        tick();
        totalCnt++; if (outValid !== 1'b0) $display("FAIL single_edge_k2 got=%b exp=0", outValid); else passCnt++;
    endtask

    task automatic test_full_backpressure();
        outReady = 1'b0;
        inValid  = 2'b01;
        for (int i = 1; i <= 6; i++) begin
            inData[7:0] = 8'(i);
            tick();
        end
        inValid = 2'b00;
        totalCnt++; if (inReady[0] !== 1'b0) $display("FAIL full_in_ready got=%b exp=0", inReady[0]); else passCnt++;
        totalCnt++; if (chCount[2:0] !== 3'd4) $display("FAIL full_count got=%0d exp=4", chCount[2:0]); else passCnt++;
        totalCnt++; if (outValid !== 1'b1 || outData !== 8'h01)
            $display("FAIL full_out_reg got=%b/%h exp=1/01", outValid, outData); else passCnt++;
        outReady = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            totalCnt++; if (outValid !== 1'b1 || outData !== 8'(i) || outCh !== 1'b0)
                $display("FAIL drain_order idx=%0d got=%b/%h/%0d exp=1/%h/0", i, outValid, outData, outCh, 8'(i)); else passCnt++;
            tick();
        end
        totalCnt++; if (outValid !== 1'b0 || chCount !== 6'd0)
            $display("FAIL drain_empty got=%b/%h exp=0/0", outValid, chCount); else passCnt++;
    endtask

    task automatic test_arbitration();
        logic [7:0] expData [6];
        logic       expCh   [6];
`ifdef HIER_INCLUDE_B_STRICT_PRIO_EN
        expData = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
        expCh   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
        expData = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
        expCh   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
        resetPulse();
        outReady = 1'b0;
        inValid  = 2'b11;
        for (int i = 0; i < 3; i++) begin
            inData = {8'h20 + 8'(i), 8'h10 + 8'(i)};
            tick();
        end
        inValid  = 2'b00;
        outReady = 1'b1;
        for (int k = 0; k < 6; k++) begin
            totalCnt++; if (outValid !== 1'b1 || outData !== expData[k] || outCh !== expCh[k])
                $display("FAIL arb_order idx=%0d got=%b/%h/%0d exp=1/%h/%0d", k, outValid, outData, outCh, expData[k], expCh[k]); else passCnt++;
            tick();
        end
        totalCnt++; if (outValid !== 1'b0) $display("FAIL arb_empty got=%b exp=0", outValid); else passCnt++;
    endtask

    task automatic test_random_stall();
        int         beats;
        logic       prevStall;
        logic [7:0] prevData;
        logic       prevCh;
        beats     = 0;
        prevStall = 1'b0;
        prevData  = 8'h00;
        prevCh    = 1'b0;
        resetPulse();
        for (int cyc = 0; cyc < 3000 && beats < 200; cyc++) begin
            outReady   = ($urandom_range(0, 2) != 0);
            inValid[0] = 1'b1;
            inValid[1] = ($urandom_range(0, 3) == 0);
            inData     = 16'($urandom);
            if (outValid && outReady) beats++;
            prevStall = outValid && !outReady;
            prevData  = outData;
            prevCh    = outCh;
            tick();
            totalCnt++; if (outValid !== mValid)
                $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, outValid, mValid); else passCnt++;
            if (mValid) begin
                totalCnt++; if (outData !== mData || outCh !== 1'(mCh))
                    $display("FAIL rand_data cyc=%0d got=%h/%0d exp=%h/%0d", cyc, outData, outCh, mData, mCh); else passCnt++;
            end
            totalCnt++; if (inReady !== expReady())
                $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", cyc, inReady, expReady()); else passCnt++;
            totalCnt++; if (chCount !== expCount())
                $display("FAIL rand_ch_count cyc=%0d got=%h exp=%h", cyc, chCount, expCount()); else passCnt++;
            totalCnt++; if (chCount[2:0] > 3'd4)
                $display("FAIL rand_count_bound cyc=%0d got=%0d exp<=4", cyc, chCount[2:0]); else passCnt++;
            if (prevStall) begin
                totalCnt++; if (outValid !== 1'b1 || outData !== prevData || outCh !== prevCh)
                    $display("FAIL stall_hold cyc=%0d got=%b/%h/%0d exp=1/%h/%0d", cyc, outValid, outData, outCh, prevData, prevCh); else passCnt++;
            end
        end
        totalCnt++; if (beats < 200) $display("FAIL rand_beat_budget got=%0d exp=200", beats); else passCnt++;
        inValid  = 2'b00;
        outReady = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_full_backpressure();
        test_arbitration();
        test_random_stall();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
